gpu_csr_bank: RTL

Parametrised control/status register bank for the voxel GPU, generalising the single-camera register front end. Sits between the Avalon-MM slave port and the render core. Holds N camera slots and an active-camera select, double-buffers render configuration, and sequences render kicks through a small FSM with a one-deep kick queue. Also keeps a frame counter and a maskable, sticky completion interrupt.

---
 rtl/gpu_pkg.sv | 48 ++++
 rtl/gpu_csr_bank_if.sv | 18 +
 rtl/gpu_kick_fsm.sv | 85 ++++++++
 rtl/gpu_csr_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and address constants for the voxel GPU control/status register bank.
package gpu_pkg;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec3_t;

    typedef struct packed {
        vec3_t pos;
        vec3_t look0;
        vec3_t look1;
        vec3_t look2;
        vec3_t look3;
    } camera_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } csr_state_t;

    localparam logic [7:0] ADDR_PIXEL      = 8'h00;
    localparam logic [7:0] ADDR_VOXEL      = 8'h01;
    localparam logic [7:0] ADDR_VOXEL_CNT  = 8'h02;
    localparam logic [7:0] ADDR_PALETTE    = 8'h03;
    localparam logic [7:0] ADDR_PAL_LEN    = 8'h04;
    localparam logic [7:0] ADDR_CAM_SEL    = 8'h05;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h06;
    localparam logic [7:0] ADDR_STATUS     = 8'h0E;
    localparam logic [7:0] ADDR_CTRL       = 8'h0F;
    localparam logic [7:0] CAM_BASE        = 8'h10;
    localparam int         CAM_STRIDE      = 16;
    localparam int         CAM_FIELDS      = 15;

    // Word k of a camera slot is field k in pos.xyz, look0.xyz .. look3.xyz order.
    typedef logic [CAM_FIELDS-1:0][31:0] cam_words_t;

    function automatic camera_t words_to_cam(input cam_words_t w);
        cam_words_t f;
        for (int k = 0; k < CAM_FIELDS; k++) begin
            f[CAM_FIELDS-1-k] = w[k];
        end
        return camera_t'(f);
    endfunction

endpackage

// File: rtl/gpu_csr_bank_if.sv
// Avalon-MM slave port of the GPU register bank: zero-wait-state writes, combinational reads.
interface gpu_csr_bank_if;
    logic [7:0]  s1_address;
    logic [31:0] s1_writedata;
    logic        s1_write;
    logic [31:0] s1_readdata;
    logic        s1_waitrequest;

    modport master (
        output s1_address, s1_writedata, s1_write,
        input  s1_readdata, s1_waitrequest
    );

    modport slave (
        input  s1_address, s1_writedata, s1_write,
        output s1_readdata, s1_waitrequest
    );
endinterface

// File: rtl/gpu_kick_fsm.sv
// Render kick sequencer: IDLE/START/BUSY FSM with a one-deep kick queue,
// frame counter and sticky completion flag.
module gpu_kick_fsm
    import gpu_pkg::*;
#(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  kick,
    input  logic                  clear_irq,
    input  logic                  render_done,
    output logic                  render_start,
    output logic                  busy,
    output logic                  kick_pending,
    output logic                  irq_pending,
    output logic [FRAME_BITS-1:0] frame_count
);

    csr_state_t            state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  irqp_q, irqp_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            irqp_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            irqp_q  <= irqp_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        irqp_d       = irqp_q;
        frame_d      = frame_q;
        render_start = 1'b0;

        // Clear is applied first so a completion in the same cycle wins.
        if (clear_irq) begin
            irqp_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (kick) begin
                    state_d = START;
                end
            end
            START: begin
                render_start = 1'b1;
                state_d      = BUSY;
                if (kick) begin
                    pend_d = 1'b1;
                end
            end
            BUSY: begin
                if (render_done) begin
                    frame_d = frame_q + FRAME_BITS'(1);
                    irqp_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = (pend_q || kick) ? START : IDLE;
                end else if (kick) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign kick_pending = pend_q;
    assign irq_pending  = irqp_q;
    assign frame_count  = frame_q;

endmodule

// File: rtl/gpu_csr_bank.sv
// Control/status register bank for the voxel GPU: N camera slots, render kick sequencing,
// frame counter and maskable sticky interrupt. GPU_CSR_SHADOW_EN adds shadowed cfg_* outputs.
module gpu_csr_bank
    import gpu_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
    parameter int          NUM_CAMERAS    = 4,
    parameter int          FRAME_BITS     = 16
) (
    input  logic          clock,
    input  logic          reset,
    gpu_csr_bank_if.slave s1,
    output logic          irq,
    output logic          render_start,
    input  logic          render_done,
    output logic [31:0]   cfg_pixel_buffer,
    output logic [31:0]   cfg_voxel_buffer,
    output logic [31:0]   cfg_voxel_count,
    output logic [31:0]   cfg_palette_buffer,
    output logic [31:0]   cfg_palette_length,
    output camera_t       cfg_cam
);

    logic [31:0] pixel_q,   pixel_d;
    logic [31:0] voxel_q,   voxel_d;
    logic [31:0] vcount_q,  vcount_d;
    logic [31:0] pal_q,     pal_d;
    logic [31:0] pal_len_q, pal_len_d;
    logic [3:0]  cam_sel_q, cam_sel_d;
    logic        irq_en_q,  irq_en_d;
    logic        irq_q;
    cam_words_t  cam_q [NUM_CAMERAS];
    cam_words_t  cam_d [NUM_CAMERAS];

    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  cam_off;
    logic [3:0]  cam_idx;
    logic [3:0]  cam_fld;
    logic        cam_hit;
    logic        cfg_wr_ok;
    logic        kick;
    logic        clear_irq;
    logic        busy;
    logic        kick_pending;
    logic        irq_pending;
    logic [FRAME_BITS-1:0] frame_count;
    camera_t     live_cam;

    assign addr  = s1.s1_address;
    assign wdata = s1.s1_writedata;

    assign cam_off = addr - CAM_BASE;
    assign cam_idx = 4'(cam_off / 8'(CAM_STRIDE));
    assign cam_fld = 4'(cam_off % 8'(CAM_STRIDE));
    assign cam_hit = (addr >= CAM_BASE) && (int'(cam_idx) < NUM_CAMERAS)
                     && (int'(cam_fld) < CAM_FIELDS);

    assign kick      = s1.s1_write && (addr == ADDR_CTRL) && wdata[0];
    assign clear_irq = s1.s1_write && (addr == ADDR_CTRL) && wdata[1];

`ifdef GPU_CSR_SHADOW_EN
    assign cfg_wr_ok = 1'b1;
`else
    // Without shadows the core reads live registers, so they are frozen while a frame runs.
    assign cfg_wr_ok = !busy;
`endif

    gpu_kick_fsm #(
        .FRAME_BITS (FRAME_BITS)
    ) u_kick_fsm (
        .clock        (clock),
        .reset        (reset),
        .kick         (kick),
        .clear_irq    (clear_irq),
        .render_done  (render_done),
        .render_start (render_start),
        .busy         (busy),
        .kick_pending (kick_pending),
        .irq_pending  (irq_pending),
        .frame_count  (frame_count)
    );

    always_comb begin
        pixel_d   = pixel_q;
        voxel_d   = voxel_q;
        vcount_d  = vcount_q;
        pal_d     = pal_q;
        pal_len_d = pal_len_q;
        cam_sel_d = cam_sel_q;
        irq_en_d  = irq_en_q;
        cam_d     = cam_q;

        if (s1.s1_write) begin
            if (cfg_wr_ok) begin
                case (addr)
                    ADDR_PIXEL:     pixel_d   = wdata;
                    ADDR_VOXEL:     voxel_d   = wdata;
                    ADDR_VOXEL_CNT: vcount_d  = wdata;
                    ADDR_PALETTE:   pal_d     = wdata;
                    ADDR_PAL_LEN:   pal_len_d = wdata;
                    ADDR_CAM_SEL: begin
                        if (wdata < 32'(NUM_CAMERAS)) begin
                            cam_sel_d = wdata[3:0];
                        end
                    end
                    default: ;
                endcase
                if (cam_hit) begin
                    for (int c = 0; c < NUM_CAMERAS; c++) begin
                        if (int'(cam_idx) == c) begin
                            cam_d[c][cam_fld] = wdata;
                        end
                    end
                end
            end
            if (addr == ADDR_IRQ_EN) begin
                irq_en_d = wdata[0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_q   <= DEFAULT_BUFFER;
            voxel_q   <= '0;
            vcount_q  <= '0;
            pal_q     <= '0;
            pal_len_q <= '0;
            cam_sel_q <= '0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            for (int c = 0; c < NUM_CAMERAS; c++) begin
                cam_q[c] <= '0;
            end
        end else begin
            pixel_q   <= pixel_d;
            voxel_q   <= voxel_d;
            vcount_q  <= vcount_d;
            pal_q     <= pal_d;
            pal_len_q <= pal_len_d;
            cam_sel_q <= cam_sel_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_pending & irq_en_q;
            for (int c = 0; c < NUM_CAMERAS; c++) begin
                cam_q[c] <= cam_d[c];
            end
        end
    end

    always_comb begin
        live_cam = '0;
        for (int c = 0; c < NUM_CAMERAS; c++) begin
            if (int'(cam_sel_q) == c) begin
                live_cam = words_to_cam(cam_q[c]);
            end
        end
    end

`ifdef GPU_CSR_SHADOW_EN
    logic [31:0] pixel_s_q;
    logic [31:0] voxel_s_q;
    logic [31:0] vcount_s_q;
    logic [31:0] pal_s_q;
    logic [31:0] pal_len_s_q;
    camera_t     cam_s_q;

    // render_start marks the START cycle, so this captures on the START->BUSY edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_s_q   <= '0;
            voxel_s_q   <= '0;
            vcount_s_q  <= '0;
            pal_s_q     <= '0;
            pal_len_s_q <= '0;
            cam_s_q     <= '0;
        end else if (render_start) begin
            pixel_s_q   <= pixel_q;
            voxel_s_q   <= voxel_q;
            vcount_s_q  <= vcount_q;
            pal_s_q     <= pal_q;
            pal_len_s_q <= pal_len_q;
            cam_s_q     <= live_cam;
        end
    end

    assign cfg_pixel_buffer   = pixel_s_q;
    assign cfg_voxel_buffer   = voxel_s_q;
    assign cfg_voxel_count    = vcount_s_q;
    assign cfg_palette_buffer = pal_s_q;
    assign cfg_palette_length = pal_len_s_q;
    assign cfg_cam            = cam_s_q;
`else
    assign cfg_pixel_buffer   = pixel_q;
    assign cfg_voxel_buffer   = voxel_q;
    assign cfg_voxel_count    = vcount_q;
    assign cfg_palette_buffer = pal_q;
    assign cfg_palette_length = pal_len_q;
    assign cfg_cam            = live_cam;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_PIXEL:     rdata = pixel_q;
            ADDR_VOXEL:     rdata = voxel_q;
            ADDR_VOXEL_CNT: rdata = vcount_q;
            ADDR_PALETTE:   rdata = pal_q;
            ADDR_PAL_LEN:   rdata = pal_len_q;
            ADDR_CAM_SEL:   rdata = {28'd0, cam_sel_q};
            ADDR_IRQ_EN:    rdata = {31'd0, irq_en_q};
            ADDR_STATUS:    rdata = {16'(frame_count), 13'd0, kick_pending, irq_pending, busy};
            default:        rdata = '0;
        endcase
        if (cam_hit) begin
            for (int c = 0; c < NUM_CAMERAS; c++) begin
                if (int'(cam_idx) == c) begin
                    rdata = cam_q[c][cam_fld];
                end
            end
        end
    end

    assign s1.s1_readdata    = rdata;
    assign s1.s1_waitrequest = 1'b0;
    assign irq               = irq_q;

endmodule
